// File: rtl/mem_arbiter_if.sv
// Bundle of cache request/response and main-memory lines shared by mem_arbiter.
// slave = arbiter side, master = caches + memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_service;
    logic              i_data_valid;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr_req;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_service;
    logic              d_data_valid;
    logic              d_wr_ack;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_data, mem_data_valid,
        output i_service, i_data_valid, d_service, d_data_valid, d_wr_ack,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_data, mem_data_valid,
        input  i_service, i_data_valid, d_service, d_data_valid, d_wr_ack,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
// Define ARB_ROUND_ROBIN_EN to alternate between the I and D groups under contention.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_I  = 2'd1,
        FILL_D  = 2'd2,
        STORE_D = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   pick_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_reg;  // 0 = I-cache, 1 = D-cache

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner_reg <= 1'b0;
        end else if (state_reg == IDLE && state_next != IDLE) begin
            last_owner_reg <= (state_next != FILL_I);
        end
    end

    assign pick_i = bus.i_req && (!(bus.d_req || bus.d_wr_req) || last_owner_reg);
`else
    assign pick_i = bus.i_req && !bus.d_req && !bus.d_wr_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grants are non-preemptive and always pass back through IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_i)            state_next = FILL_I;
                else if (bus.d_req)    state_next = FILL_D;
                else if (bus.d_wr_req) state_next = STORE_D;
                else                   state_next = IDLE;
            end
            FILL_I:  if (!bus.i_req) state_next = IDLE;
            FILL_D:  if (!bus.d_req) state_next = IDLE;
            STORE_D: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.i_service    = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.d_service    = 1'b0;
        bus.d_data_valid = 1'b0;
        bus.d_wr_ack     = 1'b0;
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = {ADDR_W{1'b0}};
        bus.mem_data_in  = {DATA_W{1'b0}};
        case (state_reg)
            FILL_I: begin
                bus.i_service    = 1'b1;
                bus.i_data_valid = bus.mem_data_valid;
                bus.mem_enable   = 1'b1;
                bus.mem_addr     = bus.i_addr;
            end
            FILL_D: begin
                bus.d_service    = 1'b1;
                bus.d_data_valid = bus.mem_data_valid;
                bus.mem_enable   = 1'b1;
                bus.mem_addr     = bus.d_addr;
            end
            STORE_D: begin
                bus.d_wr_ack    = 1'b1;
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = bus.d_addr;
                bus.mem_data_in = bus.d_wr_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an ownership-level reference model.
module tb_mem_arbiter;
    localparam int O_NONE = 0;
    localparam int O_I    = 1;
    localparam int O_D    = 2;
    localparam int O_ST   = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int owner      = O_NONE;
    bit last_d     = 1'b0;
    int stores_exp = 0;
    int acks_seen  = 0;
    int i_dv_cnt;
    int d_dv_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Who owns the memory after this edge, from the arbitration rules.
    task automatic model_step();
        bit d_grp;
        bit take_i;
        if (!rst) begin
            owner  = O_NONE;
            last_d = 1'b0;
        end else begin
            case (owner)
                O_NONE: begin
                    d_grp = bus.d_req || bus.d_wr_req;
                    if (bus.i_req && d_grp) take_i = RR && last_d;
                    else                    take_i = bus.i_req;
                    if (take_i)              owner = O_I;
                    else if (bus.d_req)      owner = O_D;
                    else if (bus.d_wr_req) begin
                        owner = O_ST;
                        stores_exp++;
                    end
                    if (owner != O_NONE) last_d = (owner != O_I);
                end
                O_I:  if (!bus.i_req) owner = O_NONE;
                O_D:  if (!bus.d_req) owner = O_NONE;
                default: owner = O_NONE;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_addr;
        logic [15:0] e_data;
        e_addr = (owner == O_I) ? bus.i_addr :
                 (owner == O_D || owner == O_ST) ? bus.d_addr : 16'h0;
        e_data = (owner == O_ST) ? bus.d_wr_data : 16'h0;
        chk({tag, ".i_service"},    32'(bus.i_service),    32'(owner == O_I));
        chk({tag, ".d_service"},    32'(bus.d_service),    32'(owner == O_D));
        chk({tag, ".i_data_valid"}, 32'(bus.i_data_valid), 32'(owner == O_I && bus.mem_data_valid));
        chk({tag, ".d_data_valid"}, 32'(bus.d_data_valid), 32'(owner == O_D && bus.mem_data_valid));
        chk({tag, ".d_wr_ack"},     32'(bus.d_wr_ack),     32'(owner == O_ST));
        chk({tag, ".mem_enable"},   32'(bus.mem_enable),   32'(owner != O_NONE));
        chk({tag, ".mem_wr"},       32'(bus.mem_wr),       32'(owner == O_ST));
        chk({tag, ".mem_addr"},     32'(bus.mem_addr),     32'(e_addr));
        chk({tag, ".mem_data_in"},  32'(bus.mem_data_in),  32'(e_data));
        chk({tag, ".svc_excl"},     32'(bus.i_service & bus.d_service), 32'(0));
    endtask

    // One clock: model follows the edge, outputs checked 1ns later, D-cache drops store after ack.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        if (bus.d_wr_ack === 1'b1) begin
            acks_seen++;
            bus.d_wr_req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0100;
        bus.d_req = 1'b1; bus.d_addr = 16'h0400;
        bus.d_wr_req = 1'b0; bus.d_wr_data = 16'h0;
        bus.mem_data_valid = 1'b0;

        // Reset held with both fill requests pending
        tick("reset0");
        tick("reset1");
        chk("reset_mem_enable", 32'(bus.mem_enable), 32'(0));
        rst = 1'b1;
        tick("rst_release");
        chk("rst_release_dsvc", 32'(bus.d_service), 32'(1));
        chk("rst_release_addr", 32'(bus.mem_addr), 32'h0400);
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        tick("idle_a");
        tick("idle_b");

        // I fill alone with 8 returned words
        bus.i_req = 1'b1; bus.i_addr = 16'h1230;
        i_dv_cnt = 0; d_dv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            bus.mem_data_valid = (k >= 2 && k < 10);
            tick("ifill");
            if (bus.i_data_valid === 1'b1) i_dv_cnt++;
            if (bus.d_data_valid === 1'b1) d_dv_cnt++;
        end
        chk("ifill_i_dv_count", 32'(i_dv_cnt), 32'd8);
        chk("ifill_d_dv_count", 32'(d_dv_cnt), 32'd0);
        chk("ifill_addr", 32'(bus.mem_addr), 32'h1230);
        bus.i_req = 1'b0; bus.mem_data_valid = 1'b0;
        tick("ifill_end");
        chk("ifill_end_isvc", 32'(bus.i_service), 32'(0));

        // Fixed-priority contention: D fill first, then I after one idle cycle
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 16'h2200;
        tick("cont_grant");
        chk("cont_grant_dsvc", 32'(bus.d_service), 32'(1));
        for (int k = 0; k < 9; k++) tick("cont_hold");
        bus.d_req = 1'b0;
        tick("cont_gap");
        chk("cont_gap_isvc", 32'(bus.i_service), 32'(0));
        tick("cont_ifill");
        chk("cont_ifill_isvc", 32'(bus.i_service), 32'(1));
        bus.i_req = 1'b0;
        tick("cont_end");

        // Single-word store
        bus.d_wr_req = 1'b1; bus.d_addr = 16'h00A4; bus.d_wr_data = 16'hBEEF;
        tick("store");
        chk("store_wr",   32'(bus.mem_wr), 32'(1));
        chk("store_addr", 32'(bus.mem_addr), 32'h00A4);
        chk("store_data", 32'(bus.mem_data_in), 32'hBEEF);
        chk("store_ack",  32'(bus.d_wr_ack), 32'(1));
        tick("store_after");
        chk("store_ack_once", 32'(bus.d_wr_ack), 32'(0));

        // Stale data in IDLE and no preemption of an I fill
        bus.mem_data_valid = 1'b1;
        tick("stale");
        chk("stale_i_dv", 32'(bus.i_data_valid), 32'(0));
        chk("stale_d_dv", 32'(bus.d_data_valid), 32'(0));
        bus.mem_data_valid = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h3330;
        tick("nopre_grant");
        bus.d_req = 1'b1; bus.d_addr = 16'h4440;
        for (int k = 0; k < 3; k++) begin
            tick("nopre_hold");
            chk("nopre_isvc", 32'(bus.i_service), 32'(1));
        end
        bus.i_req = 1'b0;
        tick("nopre_release");
        tick("nopre_dfill");
        chk("nopre_dfill_dsvc", 32'(bus.d_service), 32'(1));

        // Owner drops request in the same cycle as a returned word
        bus.d_req = 1'b0; bus.mem_data_valid = 1'b1;
        #1;
        check_all("drop_same");
        chk("drop_same_d_dv", 32'(bus.d_data_valid), 32'(1));
        tick("drop_after");
        chk("drop_after_d_dv", 32'(bus.d_data_valid), 32'(0));
        bus.mem_data_valid = 1'b0;

        // After a D fill, pending store and I fill: round-robin favours I
        bus.d_req = 1'b1;
        tick("rr_dfill");
        tick("rr_dfill2");
        bus.d_req = 1'b0; bus.d_wr_req = 1'b1; bus.d_wr_data = 16'h1357; bus.i_req = 1'b1;
        tick("rr_gap");
        tick("rr_pick");
        chk("rr_pick_isvc", 32'(bus.i_service), 32'(RR));
        chk("rr_pick_ack",  32'(bus.d_wr_ack),  32'(!RR));
        bus.i_req = 1'b0;
        for (int k = 0; k < 4; k++) tick("rr_drain");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 5) == 0) bus.i_req = ~bus.i_req;
            if ($urandom_range(0, 5) == 0) bus.d_req = ~bus.d_req;
            if (!bus.d_wr_req && $urandom_range(0, 7) == 0) begin
                bus.d_wr_req  = 1'b1;
                bus.d_wr_data = 16'($urandom);
            end
            bus.i_addr = 16'($urandom);
            bus.d_addr = 16'($urandom);
            bus.mem_data_valid = 1'($urandom_range(0, 1));
            tick("rand");
        end

        chk("ack_count", 32'(acks_seen), 32'(stores_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
